// File: rtl/chacha_aead_sequencer.sv
// chacha_aead_sequencer: drives one ChaCha20-Poly1305 AEAD job (config, AAD, keystream XOR, lengths, tag).
// Optional build macro CHACHA_AEAD_TAGCHK_EN adds the decrypt tag comparator behind tag_ok_o.
module chacha_aead_sequencer #(
  parameter int LEN_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             encrypt_i,
  input  logic [LEN_W-1:0] aad_bytes_i,
  input  logic [LEN_W-1:0] pld_bytes_i,
  input  logic [127:0]     exp_tag_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [127:0]     tag_o,
  output logic             tag_ok_o,
  input  logic             in_valid_i,
  input  logic [127:0]     in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [127:0]     out_data_o,
  output logic [15:0]      out_keep_o,
  input  logic             out_ready_i,
  output logic             cfg_we_o,
  output logic             ks_req_o,
  input  logic             ks_valid_i,
  input  logic [511:0]     ks_data_i,
  output logic             aad_valid_o,
  output logic [127:0]     aad_data_o,
  output logic [15:0]      aad_keep_o,
  input  logic             aad_ready_i,
  output logic             pld_valid_o,
  output logic [127:0]     pld_data_o,
  output logic [15:0]      pld_keep_o,
  input  logic             pld_ready_i,
  output logic             len_valid_o,
  output logic [127:0]     len_block_o,
  input  logic             len_ready_i,
  input  logic             tag_pre_xor_valid_i,
  input  logic [127:0]     tag_pre_xor_i,
  input  logic             tagmask_valid_i,
  input  logic [127:0]     tagmask_i
);
  localparam logic [3:0] S_IDLE = 4'd0, S_CFG = 4'd1, S_AAD = 4'd2, S_KSREQ = 4'd3, S_KSWAIT = 4'd4,
                         S_PLD = 4'd5, S_LEN = 4'd6, S_TAG = 4'd7, S_FIN = 4'd8;
  localparam logic [LEN_W-1:0] BEAT_BYTES = LEN_W'(16);

  logic [3:0]       state_q, state_d;
  logic             enc_q, enc_d;
  logic [LEN_W-1:0] aad_len_q, aad_len_d, pld_len_q, pld_len_d;
  logic [LEN_W-1:0] aad_rem_q, aad_rem_d, pld_rem_q, pld_rem_d;
  logic [1:0]       beat_q, beat_d;
  logic [511:0]     ks_q, ks_d;
  logic [127:0]     tpx_q, tpx_d, tm_q, tm_d, tag_q, tag_d;
  logic             tpx_v_q, tpx_v_d, tm_v_q, tm_v_d;

  function automatic logic [15:0] keep_of(input logic [LEN_W-1:0] rem);
    if (rem >= BEAT_BYTES) return 16'hFFFF;
    return (16'h1 << rem[3:0]) - 16'h1;
  endfunction

  logic [15:0]  aad_keep, pld_keep;
  logic [127:0] pld_mask, ks_beat, ct;
  logic         in_aad, in_pld, in_len, aad_last, pld_last, pld_xfer;

  assign in_aad   = (state_q == S_AAD);
  assign in_pld   = (state_q == S_PLD);
  assign in_len   = (state_q == S_LEN);
  assign aad_keep = keep_of(aad_rem_q);
  assign pld_keep = keep_of(pld_rem_q);
  assign aad_last = (aad_rem_q <= BEAT_BYTES);
  assign pld_last = (pld_rem_q <= BEAT_BYTES);
  assign ks_beat  = ks_q[{beat_q, 7'd0} +: 128];
  assign ct       = (in_data_i ^ ks_beat) & pld_mask;
  // payload moves only when host, core and sink can all take it together
  assign pld_xfer = in_pld & in_valid_i & pld_ready_i & out_ready_i;

  for (genvar i = 0; i < 16; i++) begin : g_mask
    assign pld_mask[8*i +: 8] = {8{pld_keep[i]}};
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_FIN);
  assign cfg_we_o    = (state_q == S_CFG);
  assign ks_req_o    = (state_q == S_KSREQ);
  assign in_ready_o  = (in_aad & aad_ready_i) | pld_xfer;
  assign aad_valid_o = in_aad & in_valid_i;
  assign aad_data_o  = in_aad ? in_data_i : '0;
  assign aad_keep_o  = in_aad ? aad_keep : '0;
  assign pld_valid_o = in_pld & in_valid_i;
  assign out_valid_o = in_pld & in_valid_i;
  assign out_data_o  = in_pld ? ct : '0;
  assign pld_data_o  = in_pld ? (enc_q ? ct : (in_data_i & pld_mask)) : '0;
  assign out_keep_o  = in_pld ? pld_keep : '0;
  assign pld_keep_o  = in_pld ? pld_keep : '0;
  assign len_valid_o = in_len;
  assign len_block_o = in_len ? {64'(pld_len_q), 64'(aad_len_q)} : '0;
  assign tag_o       = tag_q;

`ifdef CHACHA_AEAD_TAGCHK_EN
  logic [127:0] exp_tag_q, exp_tag_d;
  logic         tag_ok_q, tag_ok_d;
  assign tag_ok_o = tag_ok_q;
`else
  logic unused_exp_tag;
  assign unused_exp_tag = ^exp_tag_i;
  assign tag_ok_o       = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    enc_d     = enc_q;
    aad_len_d = aad_len_q;
    pld_len_d = pld_len_q;
    aad_rem_d = aad_rem_q;
    pld_rem_d = pld_rem_q;
    beat_d    = beat_q;
    ks_d      = ks_q;
    tpx_d     = tpx_q;
    tpx_v_d   = tpx_v_q;
    tm_d      = tm_q;
    tm_v_d    = tm_v_q;
    tag_d     = tag_q;
`ifdef CHACHA_AEAD_TAGCHK_EN
    exp_tag_d = exp_tag_q;
    tag_ok_d  = tag_ok_q;
`endif
    unique case (state_q)
      S_IDLE: if (start_i) begin
        state_d   = S_CFG;
        enc_d     = encrypt_i;
        aad_len_d = aad_bytes_i;
        pld_len_d = pld_bytes_i;
        aad_rem_d = aad_bytes_i;
        pld_rem_d = pld_bytes_i;
        tpx_v_d   = 1'b0;
        tm_v_d    = 1'b0;
`ifdef CHACHA_AEAD_TAGCHK_EN
        exp_tag_d = exp_tag_i;
`endif
      end
      S_CFG: state_d = (aad_len_q != '0) ? S_AAD : (pld_len_q != '0) ? S_KSREQ : S_LEN;
      S_AAD: if (in_valid_i && aad_ready_i) begin
        aad_rem_d = aad_last ? '0 : aad_rem_q - BEAT_BYTES;
        if (aad_last) state_d = (pld_len_q != '0) ? S_KSREQ : S_LEN;
      end
      S_KSREQ: state_d = S_KSWAIT;
      S_KSWAIT: if (ks_valid_i) begin
        ks_d    = ks_data_i;
        beat_d  = 2'd0;
        state_d = S_PLD;
      end
      S_PLD: if (pld_xfer) begin
        pld_rem_d = pld_last ? '0 : pld_rem_q - BEAT_BYTES;
        beat_d    = beat_q + 2'd1;
        if (pld_last) state_d = S_LEN;
        else if (beat_q == 2'd3) state_d = S_KSREQ;
      end
      S_LEN: if (len_ready_i) state_d = S_TAG;
      S_TAG: begin
        if (tag_pre_xor_valid_i) begin
          tpx_d   = tag_pre_xor_i;
          tpx_v_d = 1'b1;
        end
        if (tagmask_valid_i) begin
          tm_d   = tagmask_i;
          tm_v_d = 1'b1;
        end
        if (tpx_v_q && tm_v_q) begin
          tag_d   = tpx_q ^ tm_q;
          state_d = S_FIN;
`ifdef CHACHA_AEAD_TAGCHK_EN
          tag_ok_d = !enc_q && ((tpx_q ^ tm_q) == exp_tag_q);
`endif
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      enc_q     <= 1'b0;
      aad_len_q <= '0;
      pld_len_q <= '0;
      aad_rem_q <= '0;
      pld_rem_q <= '0;
      beat_q    <= '0;
      ks_q      <= '0;
      tpx_q     <= '0;
      tpx_v_q   <= 1'b0;
      tm_q      <= '0;
      tm_v_q    <= 1'b0;
      tag_q     <= '0;
`ifdef CHACHA_AEAD_TAGCHK_EN
      exp_tag_q <= '0;
      tag_ok_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      enc_q     <= enc_d;
      aad_len_q <= aad_len_d;
      pld_len_q <= pld_len_d;
      aad_rem_q <= aad_rem_d;
      pld_rem_q <= pld_rem_d;
      beat_q    <= beat_d;
      ks_q      <= ks_d;
      tpx_q     <= tpx_d;
      tpx_v_q   <= tpx_v_d;
      tm_q      <= tm_d;
      tm_v_q    <= tm_v_d;
      tag_q     <= tag_d;
`ifdef CHACHA_AEAD_TAGCHK_EN
      exp_tag_q <= exp_tag_d;
      tag_ok_q  <= tag_ok_d;
`endif
    end
  end

endmodule

// File: tb/tb_chacha_aead_sequencer.sv
// Randomized bench for chacha_aead_sequencer: host, keystream, core and sink responders plus a byte-level model.
module tb_chacha_aead_sequencer;
  logic         clk, rst_n, start, encrypt;
  logic [31:0]  aad_bytes, pld_bytes;
  logic [127:0] exp_tag;
  logic         busy, done, tag_ok;
  logic [127:0] tag;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, out_data;
  logic [15:0]  out_keep;
  logic         cfg_we, ks_req, ks_valid;
  logic [511:0] ks_data;
  logic         aad_valid, aad_ready, pld_valid, pld_ready, len_valid, len_ready;
  logic [127:0] aad_data, pld_data, len_block;
  logic [15:0]  aad_keep, pld_keep;
  logic         tpx_valid, tm_valid;
  logic [127:0] tpx_data, tm_data;

  int n_tests = 0;
  int n_fail  = 0;

  chacha_aead_sequencer dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .encrypt_i(encrypt),
    .aad_bytes_i(aad_bytes), .pld_bytes_i(pld_bytes), .exp_tag_i(exp_tag),
    .busy_o(busy), .done_o(done), .tag_o(tag), .tag_ok_o(tag_ok),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_keep_o(out_keep), .out_ready_i(out_ready),
    .cfg_we_o(cfg_we), .ks_req_o(ks_req), .ks_valid_i(ks_valid), .ks_data_i(ks_data),
    .aad_valid_o(aad_valid), .aad_data_o(aad_data), .aad_keep_o(aad_keep), .aad_ready_i(aad_ready),
    .pld_valid_o(pld_valid), .pld_data_o(pld_data), .pld_keep_o(pld_keep), .pld_ready_i(pld_ready),
    .len_valid_o(len_valid), .len_block_o(len_block), .len_ready_i(len_ready),
    .tag_pre_xor_valid_i(tpx_valid), .tag_pre_xor_i(tpx_data),
    .tagmask_valid_i(tm_valid), .tagmask_i(tm_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Bytes still owed in a segment decide which lanes of a beat are live.
  function automatic logic [15:0] keep_exp(input int total, input int beat);
    int rem;
    rem = total - 16 * beat;
    if (rem >= 16) return 16'hFFFF;
    return 16'((1 << rem) - 1);
  endfunction

  function automatic logic [127:0] mask_of(input logic [15:0] k);
    logic [127:0] m;
    for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, "_busy"}, busy, 0);
    check_eq({name, "_outs"}, {done, tag_ok, in_ready, out_valid, cfg_we, ks_req,
                               aad_valid, pld_valid, len_valid}, 0);
    check_eq({name, "_data"}, out_data | pld_data | aad_data | len_block | tag, 0);
    check_eq({name, "_keep"}, {out_keep, pld_keep, aad_keep}, 0);
  endtask

  // Entered and left at a drive point (1 time unit after a rising edge).
  task automatic run_job(input logic enc, input int aad, input int pld, input int tm_at,
                         input int tpx_at, input logic match, input logic bp, input logic abort);
    logic [127:0] aad_arr[32];
    logic [127:0] pld_arr[32];
    logic [511:0] ksb[8];
    logic [127:0] tpx, tm, etag, exp_out, exp_pld, prev_out;
    logic [15:0]  k;
    int na, np, nks, ai, pi, hi, ks_seen, ks_given, ks_wait, cfg_cnt, aval_cnt, pval_cnt, tc, lo_left;
    logic ks_pend, in_tag, fin, prev_pend, host_adv, pv_seen, exp_ok;
    na = (aad + 15) / 16;
    np = (pld + 15) / 16;
    nks = (pld + 63) / 64;
    for (int i = 0; i < 32; i++) begin
      aad_arr[i] = rnd128();
      pld_arr[i] = rnd128();
    end
    for (int i = 0; i < 8; i++) ksb[i] = {rnd128(), rnd128(), rnd128(), rnd128()};
    tpx = rnd128();
    tm  = rnd128();
    etag = tpx ^ tm;
    if (!match) etag[$urandom_range(0, 127)] ^= 1'b1;
`ifdef CHACHA_AEAD_TAGCHK_EN
    exp_ok = !enc && match;
`else
    exp_ok = 1'b0;
`endif
    ai = 0; pi = 0; hi = 0; ks_seen = 0; ks_given = 0; ks_wait = 0; cfg_cnt = 0;
    aval_cnt = 0; pval_cnt = 0; tc = 0; lo_left = 5;
    ks_pend = 0; in_tag = 0; fin = 0; prev_pend = 0; host_adv = 0; pv_seen = 0;

    start = 1'b1; encrypt = enc; aad_bytes = aad; pld_bytes = pld; exp_tag = etag;
    step();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (abort && pi == 2) begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; ks_valid = 1'b0; tpx_valid = 1'b0; tm_valid = 1'b0;
        step();
        check_all_zero("abort");
        rst_n = 1'b1;
        step();
        return;
      end
      start = (cyc == 1);
      if (cyc == 1) begin
        encrypt = ~enc; aad_bytes = $urandom_range(1, 300); pld_bytes = $urandom_range(1, 300);
        exp_tag = rnd128();
      end
      aad_ready = ($urandom_range(0, 3) != 0);
      len_ready = ($urandom_range(0, 2) != 0);
      if (bp) begin
        out_ready = cyc[0];
        pld_ready = !(pv_seen && lo_left > 0);
        if (pv_seen && lo_left > 0) lo_left--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
        pld_ready = ($urandom_range(0, 3) != 0);
      end
      if (host_adv) begin
        hi++;
        in_valid = 1'b0;
        host_adv = 0;
      end
      if (!in_valid && hi < na + np && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data = (hi < na) ? aad_arr[hi] : pld_arr[hi - na];
      end
      ks_valid = 1'b0;
      if (ks_pend) begin
        if (ks_wait == 0) begin
          ks_valid = 1'b1;
          ks_data = ksb[ks_given % 8];
          ks_given++;
          ks_pend = 0;
        end else ks_wait--;
      end
      tm_valid  = in_tag && (tc == tm_at);
      tpx_valid = in_tag && (tc == tpx_at);
      tm_data   = tm_valid ? tm : rnd128();
      tpx_data  = tpx_valid ? tpx : rnd128();
      if (in_tag) tc++;
      #1;
      if (cyc == 0) check_eq("busy_after_start", busy, 1);
      if (cfg_we) cfg_cnt++;
      if (aad_valid) aval_cnt++;
      if (pld_valid) begin
        pval_cnt++;
        pv_seen = 1;
      end
      if (ks_req) begin
        ks_seen++;
        ks_pend = 1;
        ks_wait = $urandom_range(0, 3);
      end
      if (prev_pend && out_valid) check_eq("out_stable", out_data, prev_out);
      prev_pend = 0;
      if (in_valid && in_ready) host_adv = 1;
      if (aad_valid && aad_ready) begin
        if (ai < na) begin
          check_eq("aad_data", aad_data, aad_arr[ai]);
          check_eq("aad_keep", aad_keep, keep_exp(aad, ai));
        end else check_eq("aad_extra_beat", ai, na - 1);
        ai++;
      end
      if (pld_valid && pld_ready && out_ready) begin
        check_eq("in_ready_on_pld", in_ready, 1);
        if (pi < np) begin
          k = keep_exp(pld, pi);
          exp_out = (pld_arr[pi] ^ ksb[pi / 4][128 * (pi % 4) +: 128]) & mask_of(k);
          exp_pld = enc ? exp_out : (pld_arr[pi] & mask_of(k));
          check_eq("out_data", out_data, exp_out);
          check_eq("pld_data", pld_data, exp_pld);
          check_eq("out_keep", out_keep, k);
          check_eq("pld_keep", pld_keep, k);
        end else check_eq("pld_extra_beat", pi, np - 1);
        pi++;
      end else if (out_valid) begin
        prev_pend = 1;
        prev_out = out_data;
      end
      if (len_valid && len_ready) begin
        check_eq("len_block", len_block, {64'(pld), 64'(aad)});
        in_tag = 1;
        tc = 0;
      end
      if (done) begin
        check_eq("tag", tag, tpx ^ tm);
        check_eq("tag_ok", tag_ok, exp_ok);
        check_eq("aad_beats", ai, na);
        check_eq("pld_beats", pi, np);
        check_eq("ks_req_count", ks_seen, nks);
        check_eq("cfg_we_count", cfg_cnt, 1);
        if (na == 0) check_eq("no_aad_valid", aval_cnt, 0);
        if (np == 0) check_eq("no_pld_valid", pval_cnt, 0);
        fin = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!fin) check_eq("timeout_done", 0, 1);
    in_valid = 1'b0; tpx_valid = 1'b0; tm_valid = 1'b0; ks_valid = 1'b0; start = 1'b0;
    step();
    check_eq("done_one_cycle", done, 0);
    check_eq("idle_after_fin", busy, 0);
    check_eq("tag_held", tag, tpx ^ tm);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; encrypt = 1'b0; aad_bytes = '0; pld_bytes = '0; exp_tag = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ks_valid = 1'b0; ks_data = '0;
    aad_ready = 1'b0; pld_ready = 1'b0; len_ready = 1'b0;
    tpx_valid = 1'b0; tpx_data = '0; tm_valid = 1'b0; tm_data = '0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    run_job(1'b1, 12, 20, 1, 2, 1'b1, 1'b0, 1'b0);
    run_job(1'b1, 0, 100, 0, 0, 1'b1, 1'b0, 1'b0);
    run_job(1'b0, 7, 100, 2, 1, 1'b0, 1'b0, 1'b0);
    run_job(1'b1, 0, 0, 1, 1, 1'b1, 1'b0, 1'b0);
    run_job(1'b0, 16, 32, 0, 3, 1'b1, 1'b0, 1'b0);
    run_job(1'b0, 16, 32, 0, 3, 1'b0, 1'b0, 1'b0);
    run_job(1'b1, 8, 80, 2, 0, 1'b1, 1'b1, 1'b0);
    run_job(1'b0, 8, 80, 1, 4, 1'b1, 1'b1, 1'b0);
    run_job(1'b1, 4, 100, 0, 0, 1'b1, 1'b0, 1'b1);
    run_job(1'b1, 4, 100, 1, 2, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++)
      run_job(1'($urandom_range(0, 1)), $urandom_range(0, 40), $urandom_range(0, 200),
              $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chacha_aead_sequencer.md
CHACHA_AEAD_SEQUENCER -- requirements
Module: chacha_aead_sequencer

Interface
REQ-001 Parameter LEN_W, default 32, SHALL set the width of the AAD and payload byte counts (legal range 16..64).
REQ-002 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 start / encrypt  in  1 / 1  job launch pulse; 1=encrypt, 0=decrypt, sampled with start.
REQ-005 aad_bytes / pld_bytes  in  LEN_W / LEN_W  AAD and payload byte counts, sampled with start.
REQ-006 exp_tag  in  128  expected tag for decrypt, sampled with start.
REQ-007 busy / done  out  1 / 1  job in progress; one-cycle completion pulse.
REQ-008 tag / tag_ok  out  128 / 1  final tag; decrypt compare result; both valid from done until the next start.
REQ-009 in_valid / in_data / in_ready  in / in / out  1 / 128 / 1  host source: AAD beats, then payload beats.
REQ-010 out_valid / out_data / out_keep / out_ready  out / out / out / in  1 / 128 / 16 / 1  transformed payload.
REQ-011 cfg_we  out  1  one-cycle configure pulse to the AEAD core.
REQ-012 ks_req / ks_valid / ks_data  out / in / in  1 / 1 / 512  keystream block request, return pulse, block.
REQ-013 aad_valid / aad_data / aad_keep / aad_ready  out / out / out / in  1 / 128 / 16 / 1  AAD stream to the core.
REQ-014 pld_valid / pld_data / pld_keep / pld_ready  out / out / out / in  1 / 128 / 16 / 1  ciphertext stream to the core.
REQ-015 len_valid / len_block / len_ready  out / out / in  1 / 128 / 1  length block to the core.
REQ-016 tag_pre_xor_valid / tag_pre_xor, tagmask_valid / tagmask  in  1 / 128 each  tag halves from the core.

Function
REQ-017 FSM states SHALL be IDLE, CFG, AAD, KSREQ, KSWAIT, PLD, LEN, TAG, FIN.
REQ-018 In IDLE, start SHALL latch the job inputs and move to CFG; start while busy SHALL be ignored.
REQ-019 CFG SHALL assert cfg_we for exactly one cycle, then go to AAD if aad_bytes>0, else KSREQ if pld_bytes>0, else LEN.
REQ-020 AAD SHALL forward in_data to aad_data with aad_valid=in_valid, in_ready=aad_ready; a beat transfers on in_valid&aad_ready.
REQ-021 Keep SHALL be all-ones except on the last beat of a segment, where lanes 0..(rem-1) are set (byte lane 0 = bits[7:0]).
REQ-022 After the last AAD beat, the FSM SHALL go to KSREQ if pld_bytes>0, else LEN.
REQ-023 KSREQ SHALL pulse ks_req for one cycle; KSWAIT SHALL latch ks_data on ks_valid and go to PLD with beat index 0.
REQ-024 PLD beat k SHALL use ks_data[128k+127:128k]; a beat transfers only on in_valid&pld_ready&out_ready, with in_ready high in that cycle only.
REQ-025 Encrypt: out_data = pld_data = in_data^ks. Decrypt: pld_data = in_data and out_data = in_data^ks.
REQ-026 Unkept lanes of out_data and pld_data SHALL be zero; out_keep SHALL equal pld_keep.
REQ-027 After beat 3 of a block, if payload remains, the FSM SHALL return to KSREQ; after the last payload beat it SHALL go to LEN.
REQ-028 LEN SHALL drive len_block = {zero-extended pld_bytes in bits[127:64], zero-extended aad_bytes in bits[63:0]} until len_ready.
REQ-029 TAG SHALL independently capture tag_pre_xor and tagmask on their valids, in either order or in the same cycle.
REQ-030 Once both halves are held, tag SHALL be tag_pre_xor^tagmask, and the FSM SHALL go to FIN.
REQ-031 FIN SHALL pulse done for one cycle and return to IDLE; busy SHALL be high in every non-IDLE state.
REQ-032 Valid outputs SHALL hold data stable while waiting on ready.

Reset
REQ-033 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE, including mid-job.
REQ-034 Reset SHALL clear counters and keystream/tag latches, and force all outputs to zero.
REQ-035 The first start SHALL be accepted on the cycle after rst_n rises.

Configuration
REQ-036 Macro CHACHA_AEAD_TAGCHK_EN defined: in FIN, tag_ok SHALL be 1 iff encrypt=0 and tag==exp_tag.
REQ-037 Macro CHACHA_AEAD_TAGCHK_EN undefined: tag_ok SHALL be constant 0, exp_tag SHALL be unused, and no comparator SHALL be built.

Verification
REQ-038 Encrypt, aad=12, pld=20: expect 1 AAD beat with keep=0x0FFF, 1 ks_req, 2 PLD beats with keeps 0xFFFF/0x000F, and len_block={64'd20,64'd12}.
REQ-039 Pld=100: expect 2 ks_req pulses, 7 beats, and last keep=0x000F.
REQ-040 Aad=0, pld=0: expect CFG->LEN directly, no ks_req/aad_valid/pld_valid, and done after the tag halves arrive.
REQ-041 Tagmask 3 cycles before tag_pre_xor: expect tag = XOR of both; with TAGCHK_EN and decrypt, matching exp_tag gives tag_ok=1, one flipped bit gives 0.
REQ-042 Backpressure with out_ready toggling and pld_ready low 5 cycles: expect no beat lost or duplicated and stable out_data.
REQ-043 rst_n low during PLD beat 2: expect IDLE and all outputs 0 next cycle; a new job then completes correctly.
